// File: rtl/scan_tick_gen_if.sv
// scan_tick_gen_if: bundles the control inputs and timebase/scan outputs of
//   scan_tick_gen. The master modport is the generator side, and the slave
//   modport is the consumer side, which drives en/hold/fast.
// Ports: en, hold, fast (control); tick_ms, scan_tick, scan_sq, scan_idx,
//   scan_onehot, scan_blank (status, all registered in the generator).
interface scan_tick_gen_if #(
  parameter int CHANNELS = 4,
  parameter int IDX_W    = $clog2(CHANNELS)
);
  logic                en;
  logic                hold;
  logic                fast;
  logic                tick_ms;
  logic                scan_tick;
  logic                scan_sq;
  logic [IDX_W-1:0]    scan_idx;
  logic [CHANNELS-1:0] scan_onehot;
  logic                scan_blank;

  modport master (
    input  en, hold, fast,
    output tick_ms, scan_tick, scan_sq, scan_idx, scan_onehot, scan_blank
  );

  modport slave (
    output en, hold, fast,
    input  tick_ms, scan_tick, scan_sq, scan_idx, scan_onehot, scan_blank
  );
endinterface

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: ms tick and channel-scan enables from a single clock inclk.
// Latency: all outputs are registered; en/hold/fast act on the next edge, at tick boundaries.
// Backpressure: none. en=0 freezes every counter and suppresses both tick pulses.
// Ports: inclk, rst (sync, active-high); bus (master modport) carries
//   en/hold/fast in and tick_ms/scan_tick/scan_sq/scan_idx/scan_onehot/scan_blank out.
// Optional macro SCAN_BLANK_EN adds the inter-channel blanking window.
module scan_tick_gen #(
  parameter int DIV_MS      = 100000,
  parameter int MS_PER_SCAN = 1000,
  parameter int CHANNELS    = 4,
  parameter int BLANK_MS    = 1,
  parameter int IDX_W       = $clog2(CHANNELS)
) (
  input  logic             inclk,
  input  logic             rst,
  scan_tick_gen_if.master  bus
);

  localparam int MS_W = $clog2(DIV_MS);
  // MS_PER_SCAN=1 would give a zero-width counter, so keep at least one bit.
  localparam int SC_W = (MS_PER_SCAN > 1) ? $clog2(MS_PER_SCAN) : 1;
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(DIV_MS - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(MS_PER_SCAN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

  // Reject illegal parameter sets at elaboration.
  if (DIV_MS < 2 || MS_PER_SCAN < 1 || CHANNELS < 2 || BLANK_MS < 1 ||
      BLANK_MS >= MS_PER_SCAN) begin : g_param_chk
    $error("scan_tick_gen: illegal parameter combination");
  end

  logic [MS_W-1:0]     msc, msc_nxt;
  logic [SC_W-1:0]     sc, sc_nxt;
  logic                tick_q, stick_q, sq_q, blank_q;
  logic [IDX_W-1:0]    idx_q, idx_nxt;
  logic [CHANNELS-1:0] onehot_q, onehot_nxt;
  logic                ms_wrap, step, adv, sq_nxt, blank_nxt;

  always_comb begin
    // ms_wrap marks the edge that raises tick_ms.
    ms_wrap = bus.en && (msc == MS_LAST);
    // fast is looked at only on this edge, so mid-interval changes wait for the next ms.
    step    = ms_wrap && (bus.fast || (sc == SC_LAST));
    adv     = step && !bus.hold;

    msc_nxt = msc;
    if (bus.en) msc_nxt = ms_wrap ? '0 : msc + 1'b1;

    sc_nxt = sc;
    if (ms_wrap) sc_nxt = step ? '0 : sc + 1'b1;

    // Explicit wrap keeps non-power-of-two channel counts in range.
    idx_nxt = idx_q;
    if (adv) idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    sq_nxt = step ? ~sq_q : sq_q;
  end

`ifdef SCAN_BLANK_EN
  localparam int BL_W = $clog2(BLANK_MS + 1);
  logic [BL_W-1:0] bc, bc_nxt;

  // A real channel change in normal mode loads the window, and each later ms tick
  // counts it down. The outputs release on the edge where it reaches zero.
  always_comb begin
    bc_nxt = bc;
    if (adv && !bus.fast)            bc_nxt = BL_W'(BLANK_MS);
    else if (ms_wrap && bc != '0)    bc_nxt = bc - 1'b1;
    blank_nxt = (bc_nxt != '0);
  end

  always_ff @(posedge inclk) begin
    if (rst) bc <= '0;
    else     bc <= bc_nxt;
  end
`else
  assign blank_nxt = 1'b0;
`endif

  // The decode is built from the next index so that onehot and idx move on the same edge.
  always_comb begin
    onehot_nxt = '0;
    for (int i = 0; i < CHANNELS; i++)
      onehot_nxt[i] = !blank_nxt && (idx_nxt == IDX_W'(i));
  end

  always_ff @(posedge inclk) begin
    if (rst) begin
      msc      <= '0;
      sc       <= '0;
      tick_q   <= 1'b0;
      stick_q  <= 1'b0;
      sq_q     <= 1'b0;
      idx_q    <= '0;
      onehot_q <= CHANNELS'(1);
      blank_q  <= 1'b0;
    end else begin
      msc      <= msc_nxt;
      sc       <= sc_nxt;
      tick_q   <= ms_wrap;
      stick_q  <= step;
      sq_q     <= sq_nxt;
      idx_q    <= idx_nxt;
      onehot_q <= onehot_nxt;
      blank_q  <= blank_nxt;
    end
  end

  assign bus.tick_ms     = tick_q;
  assign bus.scan_tick   = stick_q;
  assign bus.scan_sq     = sq_q;
  assign bus.scan_idx    = idx_q;
  assign bus.scan_onehot = onehot_q;
  assign bus.scan_blank  = blank_q;

endmodule

// File: tb/tb_scan_tick_gen.sv
// tb_scan_tick_gen: directed start-up sequences followed by randomized en/hold/fast/rst
// traffic. All outputs are compared every cycle against an arithmetic reference model.
module tb_scan_tick_gen;
  localparam int DIV = 4;
  localparam int MPS = 3;
  localparam int CH  = 3;
  localparam int BLK = 1;

  logic inclk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  scan_tick_gen_if #(.CHANNELS(CH)) bus ();

  scan_tick_gen #(
    .DIV_MS(DIV), .MS_PER_SCAN(MPS), .CHANNELS(CH), .BLANK_MS(BLK)
  ) dut (
    .inclk (inclk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 inclk = ~inclk;

  // Reference model state.
  int en_edges;     // number of enabled edges since reset
  int ms_in_scan;   // ms ticks since the last scan step
  int m_idx;
  int m_sq;
  int m_tick;
  int m_stick;
  int blank_left;   // ms ticks of blanking still to run
  int edge_no;      // edges since reset was released

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    en_edges = 0; ms_in_scan = 0; m_idx = 0; m_sq = 0;
    m_tick = 0; m_stick = 0; blank_left = 0; edge_no = 0;
  endtask

  // Applies the spec rules to the inputs that were present at this edge.
  task automatic model_edge();
    bit step;
    if (rst) begin
      model_reset();
      return;
    end
    edge_no++;
    m_tick = 0; m_stick = 0;
    if (!bus.en) return;
    en_edges++;
    if (en_edges % DIV != 0) return;
    m_tick = 1;
    ms_in_scan++;
    step = bus.fast || (ms_in_scan == MPS);
    if (blank_left > 0) blank_left--;
    if (step) begin
      m_stick    = 1;
      ms_in_scan = 0;
      m_sq       = 1 - m_sq;
      if (!bus.hold) begin
        m_idx = (m_idx + 1) % CH;
`ifdef SCAN_BLANK_EN
        if (!bus.fast) blank_left = BLK;
`endif
      end
    end
  endtask

  task automatic compare_all();
    int exp_oh;
    exp_oh = (blank_left > 0) ? 0 : (1 << m_idx);
    chk_eq("tick_ms",     32'(bus.tick_ms),     32'(m_tick));
    chk_eq("scan_tick",   32'(bus.scan_tick),   32'(m_stick));
    chk_eq("scan_sq",     32'(bus.scan_sq),     32'(m_sq));
    chk_eq("scan_idx",    32'(bus.scan_idx),    32'(m_idx));
    chk_eq("scan_onehot", 32'(bus.scan_onehot), 32'(exp_oh));
    chk_eq("scan_blank",  32'(bus.scan_blank),  32'(blank_left > 0));
    chk_eq("idx_range",   32'(bus.scan_idx < CH), 32'd1);
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge inclk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int first_tick;
    int first_scan;
    int found;
    model_reset();
    rst = 1'b1; bus.en = 1'b0; bus.hold = 1'b0; bus.fast = 1'b0;
    cycle(); cycle();
    // Reset values.
    chk_eq("rst_onehot", 32'(bus.scan_onehot), 32'd1);
    chk_eq("rst_idx",    32'(bus.scan_idx),    32'd0);

    // Start counting: the first tick_ms follows edge 4 and the first scan_tick follows edge 12.
    rst = 1'b0; bus.en = 1'b1;
    first_tick = 0; first_scan = 0;
    for (int i = 1; i <= 14; i++) begin
      cycle();
      if (bus.tick_ms && first_tick == 0)   first_tick = i;
      if (bus.scan_tick && first_scan == 0) first_scan = i;
      if (i == 12) begin
        chk_eq("step1_idx",    32'(bus.scan_idx),    32'd1);
        chk_eq("step1_onehot", 32'(bus.scan_onehot),
`ifdef SCAN_BLANK_EN
               32'd0);
`else
               32'd2);
`endif
        chk_eq("step1_sq",     32'(bus.scan_sq),     32'd1);
      end
    end
    chk_eq("first_tick_edge", 32'(first_tick), 32'd4);
    chk_eq("first_scan_edge", 32'(first_scan), 32'd12);

    // Hold across a step: idx stays put, and sq keeps toggling (checked by the model).
    bus.hold = 1'b1;
    repeat (12) cycle();
    bus.hold = 1'b0;

    // Pause with msc at 2. The next tick must come 2 enabled edges after resuming.
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      cycle();
      if (bus.tick_ms) found = 1;
    end
    chk_eq("sync_to_tick", 32'(found), 32'd1);
    cycle(); cycle();
    bus.en = 1'b0;
    repeat (5) cycle();
    bus.en = 1'b1;
    cycle();
    chk_eq("resume_no_tick", 32'(bus.tick_ms), 32'd0);
    cycle();
    chk_eq("resume_tick", 32'(bus.tick_ms), 32'd1);

    // Switch to fast mode mid-interval, then apply a one-cycle reset mid-count.
    cycle();
    bus.fast = 1'b1;
    repeat (14) cycle();
    bus.fast = 1'b0;
    repeat (6) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk_eq("midrst_idx",    32'(bus.scan_idx),    32'd0);
    chk_eq("midrst_onehot", 32'(bus.scan_onehot), 32'd1);
    chk_eq("midrst_sq",     32'(bus.scan_sq),     32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bus.en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0)   bus.hold = ~bus.hold;
      if ($urandom_range(0, 39) == 0)  bus.fast = ~bus.fast;
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
